muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the multicycle ARM core. It services ALUControl codes MUL (0100), UMULL (0101), SMULL (0110) and DIV (0111) over 32 radix-2 steps, so no single-cycle 32x32 array is needed in the ALU. The main FSM launches it with `start`, holds in a wait state while `busy` is high, and writes results on the one-cycle `done` pulse. For long multiplies it writes `result_lo` to RdLo and `result_hi` to RdHi.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_seq.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, state encoding and defaults for the iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    // Must match the ALUControl encoding produced by the main decoder.
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_UMULL = 4'b0101;
    localparam logic [3:0] OP_SMULL = 4'b0110;
    localparam logic [3:0] OP_DIV   = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    function automatic logic op_supported(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step: shift-add multiply (LSB first) or restoring divide (MSB first).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // NOTE: every output and temporary gets a default first so no path can infer a latch.
    always_comb begin
        sum    = '0;
        trial  = '0;
        diff   = '0;
        nxt_hi = acc_hi;
        nxt_lo = acc_lo;
        if (is_div) begin
            // Partial remainder gains one bit, so the trial value needs WIDTH+1 bits.
            trial = {acc_hi, acc_lo[WIDTH-1]};
            diff  = trial[WIDTH-1:0] - operand;
            if (trial >= {1'b0, operand}) begin
                nxt_hi = diff;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = trial[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum    = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, operand}) : {1'b0, acc_hi};
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/UMULL/SMULL/DIV sequencer; owns the FSM, counter and all registers.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             long_res,
    output logic             flag_n,
    output logic             flag_z,
    output logic             div_zero
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               long_q, long_d;
    logic               fn_q, fn_d;
    logic               fz_q, fz_d;
    logic               dz_q, dz_d;

    logic               is_div;
    logic               is_long;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;

    assign is_div  = (op_q == OP_DIV);
    assign is_long = (op_q == OP_UMULL) || (op_q == OP_SMULL);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (opnd_q),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        sign_d   = sign_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        long_d   = long_q;
        fn_d     = fn_q;
        fz_d     = fz_q;
        dz_d     = dz_q;
        prod     = {acc_hi_q, acc_lo_q};

        unique case (state_q)
            S_IDLE: begin
                if (start && op_supported(op)) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                cnt_d    = '0;
                acc_hi_d = '0;
                sign_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                if (is_div) begin
                    opnd_d   = b_q;
                    acc_lo_d = a_q;
                end else if (op_q == OP_SMULL) begin
                    opnd_d   = a_q[WIDTH-1] ? -a_q : a_q;
                    acc_lo_d = b_q[WIDTH-1] ? -b_q : b_q;
                end else begin
                    opnd_d   = a_q;
                    acc_lo_d = b_q;
                end
                if (is_div && (b_q == '0)) begin
                    res_lo_d = '1;
                    res_hi_d = a_q;
                    long_d   = 1'b0;
                    fn_d     = 1'b1;
                    fz_d     = 1'b0;
                    dz_d     = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_ITER;
                end
            end
            S_ITER: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if ((op_q == OP_SMULL) && sign_q) begin
                    prod = -{acc_hi_q, acc_lo_q};
                end
                res_lo_d = prod[WIDTH-1:0];
                res_hi_d = prod[2*WIDTH-1:WIDTH];
                long_d   = is_long;
                fn_d     = is_long ? prod[2*WIDTH-1] : prod[WIDTH-1];
                fz_d     = is_long ? (prod == '0) : (prod[WIDTH-1:0] == '0);
                dz_d     = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An abort discards everything computed this cycle, including result writes.
        if (flush && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            res_lo_d = res_lo_q;
            res_hi_d = res_hi_q;
            long_d   = long_q;
            fn_d     = fn_q;
            fz_d     = fz_q;
            dz_d     = dz_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            sign_q   <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            long_q   <= 1'b0;
            fn_q     <= 1'b0;
            fz_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            sign_q   <= sign_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            long_q   <= long_d;
            fn_q     <= fn_d;
            fz_q     <= fz_d;
            dz_q     <= dz_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign long_res  = long_q;
    assign flag_n    = fn_q;
    assign flag_z    = fz_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, random ops against an arithmetic model, corner sequences.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    op = 4'b0000;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          flush = 1'b0;
    logic          busy, done, long_res, flag_n, flag_z, div_zero;
    logic [W-1:0]  result_lo, result_hi;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .long_res  (long_res),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         lng;
        logic         n;
        logic         z;
        logic         dz;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model from plain 64-bit arithmetic.
    task automatic model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output vec_t v);
        logic [63:0] p;
        v.op = mop; v.a = ma; v.b = mb; v.dz = 1'b0; v.lat = 34;
        if (mop == OP_DIV) begin
            if (mb == 0) begin
                v.lo = 32'hFFFF_FFFF; v.hi = ma; v.dz = 1'b1; v.lat = 1;
            end else begin
                v.lo = ma / mb; v.hi = ma % mb;
            end
            v.lng = 1'b0;
            v.n = v.lo[W-1]; v.z = (v.lo == 0);
        end else begin
            if (mop == OP_SMULL) p = $signed({{32{ma[31]}}, ma}) * $signed({{32{mb[31]}}, mb});
            else                 p = {32'b0, ma} * {32'b0, mb};
            v.lo = p[31:0]; v.hi = p[63:32];
            v.lng = (mop != OP_MUL);
            v.n = v.lng ? p[63] : p[31];
            v.z = v.lng ? (p == 0) : (p[31:0] == 0);
        end
    endtask

    task automatic launch(input logic [3:0] lop, input logic [W-1:0] la, input logic [W-1:0] lb);
        @(negedge clk);
        start = 1'b1; op = lop; a = la; b = lb;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'b0000; a = '0; b = '0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: done=%0b after %0d edges, expected 1", name, done, n);
        end
    endtask

    task automatic check_result(input string name, input vec_t v, input int lat);
        check({name, "_lat"}, 64'(lat), 64'(v.lat));
        check({name, "_lo"}, 64'(result_lo), 64'(v.lo));
        check({name, "_hi"}, 64'(result_hi), 64'(v.hi));
        check({name, "_long"}, 64'(long_res), 64'(v.lng));
        check({name, "_dz"}, 64'(div_zero), 64'(v.dz));
        if (!v.dz) begin
            check({name, "_n"}, 64'(flag_n), 64'(v.n));
            check({name, "_z"}, 64'(flag_z), 64'(v.z));
        end
        @(posedge clk);
        #1;
        check({name, "_pulse"}, {62'b0, done, busy}, 64'b0);
        check({name, "_hold"}, {result_hi, result_lo}, {v.hi, v.lo});
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        launch(v.op, v.a, v.b);
        wait_done(name, lat);
        check_result(name, v, lat);
    endtask

    vec_t tbl[10];
    vec_t m, m2;
    int   lat, seen;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    initial begin
        tbl[0] = '{OP_MUL,   32'd7,          32'd6,          32'h0000_002A, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 34};
        tbl[1] = '{OP_UMULL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 32'hFFFF_FFFE,  1'b1, 1'b1, 1'b0, 1'b0, 34};
        tbl[2] = '{OP_SMULL, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 32'hFFFF_FFFF,  1'b1, 1'b1, 1'b0, 1'b0, 34};
        tbl[3] = '{OP_SMULL, 32'd0,          32'hFFFF_FFF7,  32'h0,         32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 34};
        tbl[4] = '{OP_DIV,   32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002,  1'b0, 1'b0, 1'b0, 1'b0, 34};
        tbl[5] = '{OP_DIV,   32'h1234,       32'd0,          32'hFFFF_FFFF, 32'h0000_1234,  1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[6] = '{OP_SMULL, 32'h8000_0000,  32'h8000_0000,  32'h0,         32'h4000_0000,  1'b1, 1'b0, 1'b0, 1'b0, 34};
        tbl[7] = '{OP_DIV,   32'd5,          32'd9,          32'h0,         32'h5,          1'b0, 1'b0, 1'b1, 1'b0, 34};
        tbl[8] = '{OP_MUL,   32'h8000_0000,  32'd2,          32'h0,         32'h1,          1'b0, 1'b0, 1'b1, 1'b0, 34};
        tbl[9] = '{OP_SMULL, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0001, 32'hFFFF_FFFF,  1'b1, 1'b1, 1'b0, 1'b0, 34};

        #12;
        check("reset_state", {busy, done, long_res, flag_n, flag_z, div_zero, result_hi, result_lo},
              70'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Unsupported op is ignored.
        launch(4'b0010, 32'd1, 32'd1);
        check("bad_op_idle", 64'(busy), 64'b0);

        for (int i = 0; i < 40; i++) begin
            rop = OP_MUL + 4'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            model(rop, ra, rb, m);
            run_vec($sformatf("rnd%0d", i), m);
        end

        // start during ITER is ignored; the original op completes unchanged.
        model(OP_UMULL, 32'h1234_5678, 32'h9ABC_DEF0, m);
        launch(OP_UMULL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (11) begin @(posedge clk); #1; end
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign_start", lat);
        check_result("ign_start", m, lat + 12);

        // flush at ITER cycle 20: idle on the next edge, no done, results kept.
        launch(OP_MUL, 32'd5, 32'd5);
        repeat (21) begin @(posedge clk); #1; end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'b0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_keep", {result_hi, result_lo}, {m.hi, m.lo});
        model(OP_MUL, 32'd3, 32'd3, m2);
        run_vec("after_flush", m2);

        // Asynchronous reset between edges during ITER.
        launch(OP_MUL, 32'd7, 32'd7);
        repeat (15) begin @(posedge clk); #1; end
        #1;
        reset = 1'b0;
        #1;
        check("async_rst", {61'b0, busy, done, (result_lo != 0)}, 64'b0);
        @(negedge clk);
        reset = 1'b1;
        model(OP_MUL, 32'd2, 32'd2, m2);
        run_vec("after_rst", m2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
